mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the MIPS execute stage.
- Accepts MULT/MULTU/DIV/DIVU requests from the decoded instruction stream and holds the pipeline with a stall.
- Sequences a 1-bit-per-cycle iterative divider and a registered multiplier.
- Presents a 64-bit {HI,LO} result with a one-cycle HI/LO write-enable pulse for the hilo register.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits. Must be a power of two and at least 8.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start_mul  in  1  execute-stage instruction is MULT/MULTU
- start_div  in  1  execute-stage instruction is DIV/DIVU
- signed_op  in  1  1 = signed (MULT/DIV), 0 = unsigned
- a_i  in  WIDTH  rs operand (dividend or multiplicand)
- b_i  in  WIDTH  rt operand (divisor or multiplier)
- flush_i  in  1  annul the current operation (exception or branch flush)
- stall_o  out  1  hold the pipeline
- done_o  out  1  result valid this cycle
- hilo_we_o  out  1  write {hi_o,lo_o} into HI/LO this cycle
- hi_o  out  WIDTH  remainder (div) or product[2W-1:W] (mul)
- lo_o  out  WIDTH  quotient (div) or product[W-1:0] (mul)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; stall_o, done_o, hilo_we_o = 0; hi_o, lo_o = 0; all internal registers cleared.
- States: IDLE, MUL, DIV_RUN, DONE.
- IDLE:
  - If start_div and start_mul are both 1, start_div wins.
  - On start, latch a_i, b_i and signed_op.
  - start_mul -> MUL.
  - start_div with b_i!=0 -> DIV_RUN with counter=WIDTH.
  - start_div with b_i==0 -> DONE with hi=a_i, lo={WIDTH{1}}.
- MUL: register the full product (signed or unsigned per the latched flag); -> DONE.
- DIV_RUN:
  - Restoring division on operand magnitudes, one quotient bit per cycle; counter decrements each cycle.
  - At counter==1 -> DONE.
  - Sign fix-up is applied when entering DONE: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Signed -2^(W-1) / -1: lo = 0x80000000, hi = 0 (no trap).
- DONE: done_o=1, hilo_we_o=1, stall_o=0; -> IDLE next cycle. start_* inputs are ignored in DONE, because the same instruction is still presented.
- stall_o is combinational:
  - 1 in IDLE when start_mul|start_div and flush_i=0.
  - 1 in MUL and DIV_RUN.
  - 0 in DONE.
- Latency from the start cycle to the DONE cycle:
  - mul: 2 cycles.
  - div: WIDTH+1 cycles (33).
  - divide-by-zero: 1 cycle.
- flush_i=1 in any state: next state is IDLE, and hilo_we_o/done_o are forced 0 that cycle. A start seen with flush_i=1 is ignored.
- hi_o/lo_o hold their last result until the next DONE and are not cleared on flush.
- Reset asserted mid-operation aborts immediately with no write.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in IDLE with start_div and |a| < |b| (magnitudes, b!=0), go directly to DONE with lo=0, hi=a_i. Latency is 1 cycle.
- Undefined: every nonzero-divisor divide takes the full WIDTH+1 cycles.

Decomposition:
- Shared package mdu_pkg:
  - state enum (IDLE, MUL, DIV_RUN, DONE);
  - WIDTH default constant;
  - divide-by-zero lo constant.
- Sub-module div_core holds the iterative restoring datapath: magnitude registers, partial remainder, shift/subtract step, bit counter.
- mdu_ctrl owns the state machine, sign handling, multiplier and outputs.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> stall high 2 cycles; DONE with hi=0xFFFFFFFF, lo=0xFFFFFFEB, hilo_we pulse of 1 cycle.
- DIVU a=100, b=7 -> stall for 33 cycles; DONE with lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIV by b=0, a=5 -> 1-cycle DONE with hi=5, lo=0xFFFFFFFF.
- Start DIVU, assert flush_i at cycle 10 -> IDLE the next cycle, no hilo_we, stall drops, hi/lo unchanged; resetn pulsed low mid-divide -> all outputs 0 asynchronously.
- With MDU_EARLY_OUT_EN: DIVU a=3, b=9 -> DONE in 1 cycle with lo=0, hi=3; without the macro, the same stimulus takes 33 cycles with an identical result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared state encoding and constants for the MIPS multiply/divide unit.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   // Divide-by-zero writes an all-ones quotient; replicated to WIDTH at the use site.
   localparam logic DIV0_LO_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV_RUN,
      DONE
   } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage (master) and the MDU (slave).
interface mdu_if import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
);
   logic             start_mul;
   logic             start_div;
   logic             signed_op;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             flush_i;
   logic             stall_o;
   logic             done_o;
   logic             hilo_we_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_mul, start_div, signed_op, a_i, b_i, flush_i,
      input  stall_o, done_o, hilo_we_o, hi_o, lo_o
   );

   modport slave (
      input  start_mul, start_div, signed_op, a_i, b_i, flush_i,
      output stall_o, done_o, hilo_we_o, hi_o, lo_o
   );
endinterface

// File: rtl/div_core.sv
// Restoring unsigned divider on operand magnitudes: one quotient bit per step, WIDTH steps.
// No backpressure; last_o flags the final step, whose results appear on the *_nxt_o outputs.
module div_core import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dvd_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic             last_o,
   output logic [WIDTH-1:0] quo_nxt_o,
   output logic [WIDTH-1:0] rem_nxt_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      // Dividend bits shift out of the quotient register into the partial remainder.
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      if (diff[WIDTH]) begin
         rem_nxt_o = shifted[WIDTH-1:0];
         quo_nxt_o = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_nxt_o = diff[WIDTH-1:0];
         quo_nxt_o = {quo_q[WIDTH-2:0], 1'b1};
      end

      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (load_i) begin
         quo_d = dvd_i;
         rem_d = '0;
         dvs_d = dvs_i;
         cnt_d = CW'(WIDTH);
      end else if (step_i) begin
         quo_d = quo_nxt_o;
         rem_d = rem_nxt_o;
         cnt_d = cnt_q - CW'(1);
      end
   end

   assign last_o = (cnt_q == CW'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mdu_ctrl.sv
// MULT/DIV controller: mul 2 cycles, div WIDTH+1, div-by-zero 1; stall_o holds the pipe until DONE.
// MDU_EARLY_OUT_EN: divides with |a| < |b| finish in 1 cycle with lo=0, hi=a.
module mdu_ctrl import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic  clk,
   input logic  resetn,
   mdu_if.slave bus
);
   mdu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               sgn_q, sgn_d;
   logic               go, div_load, div_step, div_last, stall, done;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_nxt, rem_nxt, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;

   assign go    = (bus.start_mul | bus.start_div) & ~bus.flush_i;
   assign a_mag = (bus.signed_op & bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
   assign b_mag = (bus.signed_op & bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

   // A 2W x 2W product truncated to 2W bits is exact for both signednesses.
   assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
   assign b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   assign quo_fix = (sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_nxt : quo_nxt;
   assign rem_fix = (sgn_q & a_q[WIDTH-1]) ? -rem_nxt : rem_nxt;

   div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load_i    (div_load),
      .step_i    (div_step),
      .dvd_i     (a_mag),
      .dvs_i     (b_mag),
      .last_o    (div_last),
      .quo_nxt_o (quo_nxt),
      .rem_nxt_o (rem_nxt)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      div_load = 1'b0;
      div_step = 1'b0;
      stall    = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (go) begin
               stall = 1'b1;
               a_d   = bus.a_i;
               b_d   = bus.b_i;
               sgn_d = bus.signed_op;
               if (bus.start_div) begin
                  if (bus.b_i == '0) begin
                     state_d = DONE;
                     hi_d    = bus.a_i;
                     lo_d    = {WIDTH{DIV0_LO_FILL}};
`ifdef MDU_EARLY_OUT_EN
                  end else if (a_mag < b_mag) begin
                     state_d = DONE;
                     hi_d    = bus.a_i;
                     lo_d    = '0;
`endif
                  end else begin
                     state_d  = DIV_RUN;
                     div_load = 1'b1;
                  end
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            stall        = 1'b1;
            state_d      = DONE;
            {hi_d, lo_d} = prod;
         end
         DIV_RUN: begin
            stall    = 1'b1;
            div_step = 1'b1;
            if (div_last) begin
               state_d = DONE;
               hi_d    = rem_fix;
               lo_d    = quo_fix;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flush annuls whatever is in flight; HI/LO keep their last committed value.
      if (bus.flush_i) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.stall_o   = stall & resetn;
   assign bus.done_o    = done;
   assign bus.hilo_we_o = done;
   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: arithmetic/latency reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_mdu_ctrl;
   localparam int W = 32;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   nchk   = 0;
   int   nerr   = 0;
   bit   chk_en = 1'b0;
   int   we_cnt = 0;

   mdu_if #(.WIDTH(W)) bus ();

   mdu_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: results from plain integer arithmetic, timing from the operation latency.
   int          m_cnt  = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic [63:0] m_pend = '0;
   int          m_lat  = 0;
   bit          m_mul  = 1'b0;

   function automatic logic [63:0] ref_result(input bit mul, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      if (mul) return 64'(sa * sb);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int ref_latency(input bit mul, input bit sgn,
                                      input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (mul) return 2;
      if (b == 32'd0) return 1;
      sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      if (sa < 0) sa = -sa;
      if (sb < 0) sb = -sb;
`ifdef MDU_EARLY_OUT_EN
      if (sa < sb) return 1;
`else
      if (sa < sb) return 33;
`endif
      return 33;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_cnt  = 0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (bus.flush_i) begin
         m_cnt  = 0;
         m_done = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_done       = 1'b1;
            {m_hi, m_lo} = m_pend;
         end
      end else if (bus.start_mul | bus.start_div) begin
         m_mul  = !bus.start_div;
         m_pend = ref_result(m_mul, bus.signed_op, bus.a_i, bus.b_i);
         m_lat  = ref_latency(m_mul, bus.signed_op, bus.a_i, bus.b_i);
         if (m_lat == 1) begin
            m_done       = 1'b1;
            {m_hi, m_lo} = m_pend;
         end else begin
            m_cnt = m_lat - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.hilo_we_o) we_cnt++;
      if (chk_en) begin
         check("cyc_stall", 64'(bus.stall_o),
               64'(resetn && !m_done &&
                   (m_cnt > 0 || ((bus.start_mul || bus.start_div) && !bus.flush_i))));
         check("cyc_done", 64'(bus.done_o), 64'(m_done && !bus.flush_i));
         check("cyc_we", 64'(bus.hilo_we_o), 64'(m_done && !bus.flush_i));
         check("cyc_hi", 64'(bus.hi_o), 64'(m_hi));
         check("cyc_lo", 64'(bus.lo_o), 64'(m_lo));
      end
   end

   task automatic run_op(input string name, input bit mul, input bit div, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int elat);
      int          lat  = 0;
      bit          seen = 1'b0;
      logic [31:0] hi   = '0;
      logic [31:0] lo   = '0;
      @(posedge clk); #1;
      bus.start_mul = mul;
      bus.start_div = div;
      bus.signed_op = sgn;
      bus.a_i       = a;
      bus.b_i       = b;
      we_cnt        = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (bus.stall_o) lat++;
         if (bus.done_o) begin
            seen = 1'b1;
            hi   = bus.hi_o;
            lo   = bus.lo_o;
         end
      end
      @(posedge clk); #1;
      bus.start_mul = 1'b0;
      bus.start_div = 1'b0;
      @(negedge clk);
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_hi"}, 64'(hi), 64'(eh));
      check({name, "_lo"}, 64'(lo), 64'(el));
      check({name, "_stall_cycles"}, 64'(lat), 64'(elat));
      check({name, "_we_pulses"}, 64'(we_cnt), 64'd1);
   endtask

   initial begin
      int div_small_lat;
`ifdef MDU_EARLY_OUT_EN
      div_small_lat = 1;
`else
      div_small_lat = 33;
`endif
      bus.start_mul = 1'b1;
      bus.start_div = 1'b0;
      bus.signed_op = 1'b0;
      bus.a_i       = '0;
      bus.b_i       = '0;
      bus.flush_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 64'(bus.stall_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_we", 64'(bus.hilo_we_o), 64'd0);
      check("rst_hi", 64'(bus.hi_o), 64'd0);
      check("rst_lo", 64'(bus.lo_o), 64'd0);
      bus.start_mul = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk_en = 1'b1;

      run_op("mult_neg3x7", 1, 0, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
      run_op("multu_max_x2", 1, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 2);
      run_op("divu_100_7", 0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      run_op("div_m7_2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("div_7_m2", 0, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
      run_op("div_ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
      run_op("div_by_zero", 0, 1, 1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
      run_op("both_starts", 1, 1, 0, 32'd20, 32'd6, 32'd2, 32'd3, 33);

      // A start that arrives together with a flush must be ignored.
      @(posedge clk); #1;
      bus.start_mul = 1'b1;
      bus.a_i       = 32'd9;
      bus.b_i       = 32'd9;
      bus.flush_i   = 1'b1;
      we_cnt        = 0;
      @(negedge clk);
      check("flush_start_stall", 64'(bus.stall_o), 64'd0);
      @(posedge clk); #1;
      bus.start_mul = 1'b0;
      bus.flush_i   = 1'b0;
      repeat (4) @(negedge clk);
      check("flush_start_we", 64'(we_cnt), 64'd0);
      check("flush_start_hi", 64'(bus.hi_o), 64'd2);
      check("flush_start_lo", 64'(bus.lo_o), 64'd3);

      run_op("divu_3_9", 0, 1, 0, 32'd3, 32'd9, 32'd3, 32'd0, div_small_lat);

      // Flush ten cycles into a divide.
      @(posedge clk); #1;
      bus.start_div = 1'b1;
      bus.signed_op = 1'b0;
      bus.a_i       = 32'd100;
      bus.b_i       = 32'd7;
      we_cnt        = 0;
      repeat (10) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(negedge clk);
      check("flush_mid_we", 64'(bus.hilo_we_o), 64'd0);
      @(posedge clk); #1;
      bus.flush_i   = 1'b0;
      bus.start_div = 1'b0;
      @(negedge clk);
      check("flush_mid_stall_after", 64'(bus.stall_o), 64'd0);
      repeat (40) @(negedge clk);
      check("flush_mid_we_total", 64'(we_cnt), 64'd0);
      check("flush_mid_hi", 64'(bus.hi_o), 64'd3);
      check("flush_mid_lo", 64'(bus.lo_o), 64'd0);

      // Reset in the middle of a divide clears outputs without waiting for a clock edge.
      @(posedge clk); #1;
      bus.start_div = 1'b1;
      bus.a_i       = 32'd100;
      bus.b_i       = 32'd7;
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_stall", 64'(bus.stall_o), 64'd0);
      check("arst_done", 64'(bus.done_o), 64'd0);
      check("arst_we", 64'(bus.hilo_we_o), 64'd0);
      check("arst_hi", 64'(bus.hi_o), 64'd0);
      check("arst_lo", 64'(bus.lo_o), 64'd0);
      @(posedge clk); #1;
      bus.start_div = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;

      run_op("multu_after_rst", 1, 0, 0, 32'd6, 32'd7, 32'd0, 32'd42, 2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
